lfsr_checker: RTL

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: 16-bit XNOR PRBS checker with search/sync/locked acquisition and windowed loss-of-lock detection
module lfsr_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int LOSS_ERRORS = 4,
    parameter int WINDOW      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sh_en,
    input  logic        bit_in,
    input  logic        cnt_clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count,
    output logic [1:0]  state
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_ERRORS + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_MAX  = EW'(LOSS_ERRORS);

    typedef enum logic [1:0] {SEARCH = 2'b00, SYNC = 2'b01, LOCKED = 2'b10} state_t;

    state_t        st, st_n;
    logic [15:0]   h, h_n;
    logic [4:0]    fill, fill_n;
    logic [GW-1:0] good, good_n;
    logic [WW-1:0] win, win_n;
    logic [EW-1:0] werr, werr_n;
    logic          pulse_n;
    logic [15:0]   errs_n;
    logic [31:0]   bits_n;
    logic          p, miss, wrap;

    assign state  = st;
    assign locked = (st == LOCKED);

    always_comb begin
        p       = ~(h[15] ^ h[14] ^ h[12] ^ h[3]);
        miss    = (bit_in != p);
        wrap    = (win == WIN_LAST);
        st_n    = st;
        h_n     = h;
        fill_n  = fill;
        good_n  = good;
        win_n   = win;
        werr_n  = werr;
        pulse_n = 1'b0;
        errs_n  = err_count;
        bits_n  = bit_count;
        if (sh_en) begin
            case (st)
                SEARCH: begin
                    h_n    = {h[14:0], bit_in};
                    fill_n = (fill == 5'd16) ? fill : fill + 5'd1;
                    // all-ones is the XNOR lock-up state and can never seed a valid generator
                    if (fill_n == 5'd16 && h_n != 16'hFFFF) begin
                        st_n   = SYNC;
                        good_n = '0;
                    end
                end
                SYNC: begin
                    if (miss) begin
                        st_n   = SEARCH;
                        fill_n = '0;
                        good_n = '0;
                    end else begin
                        h_n    = {h[14:0], p};
                        good_n = good + GW'(1);
                        if (good_n == GOOD_MAX) begin
                            st_n   = LOCKED;
                            win_n  = '0;
                            werr_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    h_n    = {h[14:0], p};
                    bits_n = (&bit_count) ? bit_count : bit_count + 32'd1;
                    win_n  = wrap ? '0 : win + WW'(1);
                    werr_n = (wrap ? '0 : werr) + EW'(miss);
                    if (miss) begin
                        pulse_n = 1'b1;
                        errs_n  = (&err_count) ? err_count : err_count + 16'd1;
                    end
                    if (werr_n == ERR_MAX) begin
                        st_n   = SEARCH;
                        fill_n = '0;
                        good_n = '0;
                    end
                end
                default: st_n = SEARCH;
            endcase
        end
        if (cnt_clr) begin
            errs_n = '0;
            bits_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= SEARCH;
            h         <= '0;
            fill      <= '0;
            good      <= '0;
            win       <= '0;
            werr      <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            st        <= st_n;
            h         <= h_n;
            fill      <= fill_n;
            good      <= good_n;
            win       <= win_n;
            werr      <= werr_n;
            err_pulse <= pulse_n;
            err_count <= errs_n;
            bit_count <= bits_n;
        end
    end
endmodule
